key_expand_seq: RTL
===================

KEY_EXPAND_SEQ -- requirements
Module: key_expand_seq

Interface
REQ-001: The block SHALL have one clock `clk`, a synchronous active-high reset `rst`, and no other clock or reset.
REQ-002: The block SHALL have these ports (name, direction, width, meaning):
- `clk`, input, 1, rising-edge clock.
- `rst`, input, 1, synchronous active-high reset.
- `start`, input, 1, request expansion of `key`; sampled only in IDLE.
- `key`, input, [0:127], AES-128 cipher key; `key[0:31]` is w0.
- `words`, output, [0:1407], expanded schedule w0..w43; `words[32*i +: 32]` is w[i]. This is the direct input to the cipher stage.
- `words_valid`, output, 1, level; `words` holds a complete, correct schedule.
- `busy`, output, 1, expansion in progress.
- `done`, output, 1, one-cycle completion pulse.

Function
REQ-003: The FSM SHALL have exactly the states IDLE, EXPAND and DONE.
REQ-004: In IDLE with `start`=1 at edge T0, the block SHALL:
- write `key` into w0..w3;
- set the word index i to 4;
- clear `words_valid`;
- move to EXPAND.
REQ-005: `key` SHALL be sampled only at T0; later changes SHALL NOT affect the result.
REQ-006: In EXPAND, each edge SHALL write exactly one word w[i] and then increment i, for i = 4..43.
REQ-007: Word computation: temp = w[i-1].
- If i mod 4 = 0: temp = SubWord(RotWord(temp)) XOR {Rcon[i/4], 24'h0}.
- Then w[i] = w[i-4] XOR temp.
REQ-008: RotWord SHALL rotate left by one byte ({b0,b1,b2,b3} -> {b1,b2,b3,b0}). SubWord SHALL apply the AES S-box to each byte using four instances of the team's existing S-box lookup.
REQ-009: Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-010: All arithmetic SHALL be 32-bit XOR only, with no carries. The index i SHALL be 6 bits wide and SHALL never exceed 44.
REQ-011: The edge that writes w43 (T40) SHALL move the FSM to DONE.
REQ-012: DONE SHALL last exactly one cycle and then return to IDLE.
REQ-013: `busy` SHALL be 1 exactly while in EXPAND: 40 cycles, from after T0 to after T40.
REQ-014: `done` SHALL be 1 exactly while in DONE, i.e. one cycle after T40. Total latency is start-edge to done = 41 cycles.
REQ-015: `words_valid` SHALL rise together with `done` and SHALL stay 1 until the next accepted `start` or `rst`.
REQ-016: `words` SHALL remain stable whenever `words_valid`=1.
REQ-017: `start` SHALL be ignored in EXPAND and DONE: no restart, no effect on i or `words`.
REQ-018: A `start` held continuously high SHALL begin a new expansion on the first IDLE cycle after DONE.
REQ-019: In EXPAND and DONE, `words` entries not yet written SHALL keep their previous contents. The `words` value is defined only while `words_valid`=1.

Reset
REQ-020: While `rst`=1 at a clock edge, the block SHALL:
- go to IDLE;
- clear i to 0;
- drive `words`=0, `words_valid`=0, `busy`=0, `done`=0.
REQ-021: `rst` SHALL take priority over `start` and over any in-progress expansion. A reset mid-EXPAND SHALL abort it, and no `done` pulse SHALL follow.
REQ-022: The first `start` after reset deasserts SHALL behave exactly as REQ-004.

Verification
REQ-023: The bench SHALL cover these directed scenarios:
- FIPS-197 App. C.1: `key`=000102030405060708090a0b0c0d0e0f, pulse `start` -> `done` pulses 41 cycles later; w4..w7 = d6aa74fd d2af72fa daa678f1 d6ab76fe; w40..w43 = 13111d7f e3944a17 f307a78b 4d2b30c5; `words_valid`=1.
- FIPS-197 App. A.1: `key`=2b7e151628aed2a6abf7158809cf4f3c -> w4=a0fafe17, w43=b6630ca6; `busy` high for exactly 40 cycles.
- Mid-run disturbance: change `key` and pulse `start` at cycle 10 of EXPAND -> result identical to the first scenario; exactly one `done` pulse.
- Reset mid-run: assert `rst` at cycle 20 of EXPAND -> next cycle: `busy`=0, `words`=0, `words_valid`=0; no `done`. A new `start` then completes correctly in 41 cycles.
- Back-to-back: hold `start`=1 across two runs with keys A then B -> `words_valid` drops on the second accept; second `done` comes 42 cycles after the first; final `words` matches key B.
- Cipher chaining: drive `words` into the cipher stage with plaintext 00112233445566778899aabbccddeeff and the App. C.1 key -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/key_expand_if.sv
// key_expand_if: request (start/key) and result
// (schedule + status) bundle of key_expand_seq.
interface key_expand_if;
  logic          start;
  logic [0:127]  key;
  logic [0:1407] words;
  logic          words_valid;
  logic          busy;
  logic          done;

  modport master (
    output start, key,
    input  words, words_valid, busy, done
  );

  modport slave (
    input  start, key,
    output words, words_valid, busy, done
  );
endinterface

// File: rtl/key_expand_seq.sv
// key_expand_seq: sequential AES-128 key schedule,
// one word per cycle into a 44-word register file.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[{a, 3'b000} +: 8];
endmodule

module key_expand_seq (
  input  logic        clk,
  input  logic        rst,
  key_expand_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  state_t      state;
  logic [5:0]  i;
  logic [31:0] w_q [44];

  logic [31:0] prev;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] temp;
  logic [31:0] nxt;
  logic [7:0]  rcon;

  assign prev = w_q[i - 6'd1];
  assign rot  = {prev[23:0], prev[31:24]};

  aes_sbox u_sb0 (.a(rot[31:24]), .y(sub[31:24]));
  aes_sbox u_sb1 (.a(rot[23:16]), .y(sub[23:16]));
  aes_sbox u_sb2 (.a(rot[15:8]),  .y(sub[15:8]));
  aes_sbox u_sb3 (.a(rot[7:0]),   .y(sub[7:0]));

  always_comb begin
    rcon = 8'h00;
    case (i[5:2])
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Round-key boundary words get the RotWord/SubWord/Rcon mix.
  assign temp = (i[1:0] == 2'b00)
              ? (sub ^ {rcon, 24'h0})
              : prev;
  assign nxt  = w_q[i - 6'd4] ^ temp;

  always_comb begin
    bus.words = '0;
    for (int k = 0; k < 44; k++)
      bus.words[32*k +: 32] = w_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      i               <= '0;
      bus.words_valid <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      for (int k = 0; k < 44; k++)
        w_q[k] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            for (int k = 0; k < 4; k++)
              w_q[k] <= bus.key[32*k +: 32];
            i               <= 6'd4;
            bus.words_valid <= 1'b0;
            bus.busy        <= 1'b1;
            state           <= EXPAND;
          end
        end
        EXPAND: begin
          w_q[i] <= nxt;
          i      <= i + 6'd1;
          if (i == 6'd43) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.words_valid <= 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
